cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run-control and I/O harness placed between the board pins and the RISC-V `Top` core on the debug FPGA build. It sequences core reset (`cpu_rst_n`) and gates the core's HALT line in one of four run modes: free-run, timed tick, debounced single-step, and hold. It also decodes data-memory stores to a mapped address into a latched, parametrised LED bank, and counts core-active cycles for bring-up.

Parameters:
NUM_LEDS, 4, width of LED bank; power of two, 2..32.
LED_ADDR, 32'h0000_0001, dmem word address of the LED register.
LED_ONEHOT, 1, 1 = one-hot decode of data[$clog2(NUM_LEDS)-1:0]; 0 = raw data[NUM_LEDS-1:0].
TICK_DIV, 50_000_000, clock cycles per timed-mode release; >= 2.
DEBOUNCE_CYCLES, 1_000_000, stable cycles required before the debounced step button changes level; >= 1.
RESET_HOLD, 16, cycles `cpu_rst_n` stays low after `sw0` deasserts; >= 1.

Ports:
CLK100MHZ  in  1  sole clock.
sw0  in  1  synchronous, active-high reset.
mode  in  2  00 RUN, 01 TIMED, 10 STEP, 11 HOLD; treated as synchronous, sampled every cycle.
step_btn  in  1  raw asynchronous push button.
dmem_addr  in  32  core `MEM_ACCESS_ADDRESS_BUS`.
dmem_wdata  in  32  core `MEM_ACCESS_DATA_OUT_BUS`.
dmem_read_wrn  in  1  core `MEM_ACCESS_READ_WRN`; 0 = write.
cpu_rst_n  out  1  to core `RST_N`.
cpu_halt  out  1  to core `HALT`; 1 = stalled.
leds  out  NUM_LEDS  latched LED bank.
active_cycles  out  32  count of cycles with cpu_rst_n=1 and cpu_halt=0.

Behaviour:
- All outputs are registered.
- Reset values while sw0=1: cpu_rst_n=0, cpu_halt=1, leds=0, active_cycles=0, prescaler=0, debounced level=0, synchroniser flops=0, FSM=RST.
- Reset FSM:
  - RST: entered whenever sw0=1, from any state, including mid-operation.
  - RST -> HOLDOFF when sw0=0. HOLDOFF counts RESET_HOLD cycles with cpu_rst_n=0 and cpu_halt=1.
  - HOLDOFF -> ACTIVE on the last count. cpu_rst_n rises exactly RESET_HOLD cycles after the first cycle with sw0=0.
  - While not in ACTIVE: cpu_halt=1, no step/tick is accepted, and LED writes are ignored.
- In ACTIVE, cpu_halt is set as follows:
  - RUN: 0.
  - HOLD: 1.
  - TIMED: prescaler counts 0..TICK_DIV-1 and wraps. cpu_halt=0 for exactly the one cycle following the prescaler=TICK_DIV-1 cycle, and 1 otherwise. The first release is TICK_DIV cycles after entering TIMED.
  - STEP: cpu_halt=0 for exactly one cycle per rising edge of the debounced button. That cycle is the one after the debounced level rises.
- Mode change: any change of mode clears the prescaler and discards a step pulse generated in the same cycle. The new mode's cpu_halt value appears the cycle after mode changes.
- Debounce:
  - step_btn passes through a 2-flop synchroniser.
  - The counter resets whenever the synchronised value equals the debounced level; otherwise it increments.
  - The debounced level takes the synchronised value when the counter reaches DEBOUNCE_CYCLES-1.
  - Bounces shorter than DEBOUNCE_CYCLES produce no step.
  - The falling edge is debounced identically and produces no pulse.
  - Holding the button produces one step only.
  - The debouncer runs in all modes, so pressing in another mode and then switching to STEP does not generate a stale step.
- LED write:
  - Trigger: ACTIVE state, dmem_read_wrn=0 and dmem_addr==LED_ADDR (full 32-bit compare).
  - Update: leds is written the next cycle. One-hot mode: leds = 1<<data[$clog2(NUM_LEDS)-1:0]. Raw mode: leds = data[NUM_LEDS-1:0].
  - Hold: leds holds until the next matching write or reset. It does not clear when the address changes.
  - Other addresses: writes to any other address, and all reads, leave leds unchanged.
  - Halted core: writes are accepted regardless of cpu_halt; the core is responsible for not strobing while halted.
- active_cycles: increments by 1 in each cycle where the registered cpu_rst_n=1 and cpu_halt=0. It wraps from 32'hFFFF_FFFF to 0.
- sw0 mid-operation: sw0 asserted at any cycle forces every reset value on the next edge. The reset overrides a same-cycle LED write or step.

Test Plan:
- RESET_HOLD=16: sw0 high for 5 cycles, then low -> cpu_rst_n rises exactly 16 cycles after sw0 falls; cpu_halt=1 and active_cycles=0 throughout.
- TIMED, TICK_DIV=4, run 20 cycles post-ACTIVE -> cpu_halt low on cycles 4, 8, 12, 16, 20 only; active_cycles=5.
- STEP, DEBOUNCE_CYCLES=8: step_btn pulse train 1,0,1,0 (2 cycles each), then held high for 20 cycles -> exactly one cpu_halt=0 cycle, occurring 2+8+1 cycles after the stable rise; a release plus a 3-cycle glitch adds no step.
- LED, NUM_LEDS=4, LED_ONEHOT=1: write data 2 to addr 1 -> leds=4'b0100 next cycle; write to addr 2 -> unchanged; read at addr 1 -> unchanged. LED_ONEHOT=0, write 32'hA -> leds=4'b1010.
- Mode change mid-count: TIMED with prescaler=2, switch to HOLD for 3 cycles, back to TIMED -> first release 4 cycles after return; no release occurs during HOLD.
- Reset mid-run: RUN mode, leds=4'b0001, active_cycles=37, assert sw0 coincident with an LED write -> next cycle leds=0, active_cycles=0, cpu_rst_n=0, cpu_halt=1.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control harness for the RISC-V core: reset sequencing, HALT gating by run mode,
// a memory-mapped LED bank and a core-active cycle counter.
module cpu_run_ctrl #(
  parameter int unsigned NUM_LEDS        = 4,
  parameter logic [31:0] LED_ADDR        = 32'h0000_0001,
  parameter bit          LED_ONEHOT      = 1'b1,
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RESET_HOLD      = 16
) (
  input  logic                CLK100MHZ,
  input  logic                sw0,
  input  logic [1:0]          mode,
  input  logic                step_btn,
  input  logic [31:0]         dmem_addr,
  input  logic [31:0]         dmem_wdata,
  input  logic                dmem_read_wrn,
  output logic                cpu_rst_n,
  output logic                cpu_halt,
  output logic [NUM_LEDS-1:0] leds,
  output logic [31:0]         active_cycles
);

  localparam int unsigned SEL_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned TK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HO_W  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [TK_W-1:0]     TK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0]     HO_LAST = HO_W'(RESET_HOLD - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_TIMED = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;

  typedef enum logic [1:0] {ST_RST, ST_HOLDOFF, ST_ACTIVE} state_t;

  state_t          state;
  logic [HO_W-1:0] holdoff_cnt;
  logic [TK_W-1:0] prescaler;
  logic [1:0]      mode_q;
  logic [1:0]      sync_q;
  logic            db_level;
  logic            db_level_d;
  logic [DB_W-1:0] db_cnt;

  logic active_next;
  logic tick;
  logic step_ok;
  logic led_wr;
  logic halt_mode;
  logic unused_wdata;

  // The RST exit edge counts as the first hold-off cycle so cpu_rst_n rises RESET_HOLD cycles after sw0 falls
  assign active_next = (state == ST_ACTIVE)
                    || (state == ST_HOLDOFF && holdoff_cnt == HO_LAST)
                    || (state == ST_RST && RESET_HOLD == 1);

  // Prescaler is held at zero outside TIMED, so a return to TIMED restarts a full period
  assign tick    = (state == ST_ACTIVE) && (prescaler == TK_LAST);
  assign step_ok = (state == ST_ACTIVE) && (mode == mode_q) && db_level && !db_level_d;
  assign led_wr  = (state == ST_ACTIVE) && !dmem_read_wrn && (dmem_addr == LED_ADDR);
  assign unused_wdata = ^dmem_wdata;

  always_comb begin
    halt_mode = 1'b1;
    case (mode)
      MODE_RUN:   halt_mode = 1'b0;
      MODE_TIMED: halt_mode = ~tick;
      MODE_STEP:  halt_mode = ~step_ok;
      default:    halt_mode = 1'b1;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (sw0) begin
      state         <= ST_RST;
      holdoff_cnt   <= '0;
      cpu_rst_n     <= 1'b0;
      cpu_halt      <= 1'b1;
      leds          <= '0;
      active_cycles <= '0;
      prescaler     <= '0;
      mode_q        <= mode;
      sync_q        <= '0;
      db_level      <= 1'b0;
      db_level_d    <= 1'b0;
      db_cnt        <= '0;
    end else begin
      mode_q     <= mode;
      sync_q     <= {sync_q[0], step_btn};
      db_level_d <= db_level;

      // Debouncer runs in every state and mode so stale presses never turn into steps
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_q[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end

      case (state)
        ST_RST: begin
          if (RESET_HOLD == 1) begin
            state <= ST_ACTIVE;
          end else begin
            state       <= ST_HOLDOFF;
            holdoff_cnt <= HO_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (holdoff_cnt == HO_LAST) state <= ST_ACTIVE;
          else holdoff_cnt <= holdoff_cnt + HO_W'(1);
        end
        ST_ACTIVE: state <= ST_ACTIVE;
        default:   state <= ST_RST;
      endcase

      cpu_rst_n <= active_next;
      cpu_halt  <= !active_next || halt_mode;

      if (state == ST_ACTIVE && mode == MODE_TIMED)
        prescaler <= (prescaler == TK_LAST) ? '0 : prescaler + TK_W'(1);
      else
        prescaler <= '0;

      if (led_wr) begin
        if (LED_ONEHOT) leds <= LED_ONE << dmem_wdata[SEL_W-1:0];
        else            leds <= dmem_wdata[NUM_LEDS-1:0];
      end

      if (cpu_rst_n && !cpu_halt) active_cycles <= active_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset hold-off, timed ticks, debounced step,
// LED decode (one-hot and raw instances) and reset during operation.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  localparam logic [1:0] M_RUN   = 2'b00;
  localparam logic [1:0] M_TIMED = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  logic        CLK100MHZ = 1'b0;
  logic        sw0 = 1'b1;
  logic [1:0]  mode = M_RUN;
  logic        step_btn = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_read_wrn = 1'b1;
  logic        cpu_rst_n;
  logic        cpu_halt;
  logic [3:0]  leds;
  logic [31:0] active_cycles;
  logic        r_unused_rst_n;
  logic        r_unused_halt;
  logic [31:0] r_unused_active;
  logic [3:0]  r_leds;

  int checks = 0;
  int errors = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  cpu_run_ctrl #(
    .NUM_LEDS(4), .LED_ADDR(32'h0000_0001), .LED_ONEHOT(1'b1),
    .TICK_DIV(4), .DEBOUNCE_CYCLES(8), .RESET_HOLD(16)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .sw0(sw0), .mode(mode), .step_btn(step_btn),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_read_wrn(dmem_read_wrn),
    .cpu_rst_n(cpu_rst_n), .cpu_halt(cpu_halt), .leds(leds), .active_cycles(active_cycles)
  );

  cpu_run_ctrl #(
    .NUM_LEDS(4), .LED_ADDR(32'h0000_0001), .LED_ONEHOT(1'b0),
    .TICK_DIV(4), .DEBOUNCE_CYCLES(8), .RESET_HOLD(16)
  ) dut_raw (
    .CLK100MHZ(CLK100MHZ), .sw0(sw0), .mode(mode), .step_btn(step_btn),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_read_wrn(dmem_read_wrn),
    .cpu_rst_n(r_unused_rst_n), .cpu_halt(r_unused_halt), .leds(r_leds),
    .active_cycles(r_unused_active)
  );

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Leaves the bench in the first ACTIVE cycle (cycle 16 after sw0 falls)
  task automatic do_reset(input logic [1:0] m);
    sw0 = 1'b1; mode = m; step_btn = 1'b0;
    dmem_read_wrn = 1'b1; dmem_addr = '0; dmem_wdata = '0;
    repeat (3) tick();
    sw0 = 1'b0;
    repeat (16) tick();
    checks++;
    if (cpu_rst_n !== 1'b1) begin
      errors++; $display("FAIL do_reset_active: cpu_rst_n=%b expected 1", cpu_rst_n);
    end
  endtask

  task automatic test_reset();
    sw0 = 1'b1; mode = M_RUN; step_btn = 1'b0;
    dmem_read_wrn = 1'b0; dmem_addr = 32'h1; dmem_wdata = 32'h1;
    repeat (5) tick();
    checks += 5;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rst_n: got %b expected 0", cpu_rst_n); end
    if (cpu_halt !== 1'b1) begin errors++; $display("FAIL reset_halt: got %b expected 1", cpu_halt); end
    if (leds !== 4'b0000) begin errors++; $display("FAIL reset_leds: got %b expected 0000", leds); end
    if (r_leds !== 4'b0000) begin errors++; $display("FAIL reset_raw_leds: got %b expected 0000", r_leds); end
    if (active_cycles !== 32'd0) begin errors++; $display("FAIL reset_active: got %0d expected 0", active_cycles); end
    sw0 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) dmem_read_wrn = 1'b1;
      checks += 4;
      if (cpu_rst_n !== (i >= 16)) begin
        errors++; $display("FAIL holdoff_rst_n cycle %0d: got %b expected %b", i, cpu_rst_n, (i >= 16));
      end
      if (cpu_halt !== (i < 16)) begin
        errors++; $display("FAIL holdoff_halt cycle %0d: got %b expected %b", i, cpu_halt, (i < 16));
      end
      if (leds !== 4'b0000) begin
        errors++; $display("FAIL holdoff_led_ignored cycle %0d: got %b expected 0000", i, leds);
      end
      if (active_cycles !== 32'd0) begin
        errors++; $display("FAIL holdoff_active cycle %0d: got %0d expected 0", i, active_cycles);
      end
    end
    tick();
    checks++;
    if (active_cycles !== 32'd1) begin errors++; $display("FAIL run_first_count: got %0d expected 1", active_cycles); end
  endtask

  task automatic test_timed();
    do_reset(M_TIMED);
    for (int c = 0; c <= 20; c++) begin
      checks++;
      if (cpu_halt !== !(c > 0 && c % 4 == 0)) begin
        errors++; $display("FAIL timed_halt cycle %0d: got %b expected %b", c, cpu_halt, !(c > 0 && c % 4 == 0));
      end
      tick();
    end
    checks++;
    if (active_cycles !== 32'd5) begin errors++; $display("FAIL timed_active: got %0d expected 5", active_cycles); end
  endtask

  task automatic test_mode_change();
    // Continues from cycle 21 of test_timed, prescaler=2 in cycle 22
    tick();
    mode = M_HOLD;
    checks++;
    if (cpu_halt !== 1'b1) begin errors++; $display("FAIL mode_halt cycle 22: got %b expected 1", cpu_halt); end
    for (int c = 23; c <= 29; c++) begin
      tick();
      if (c == 25) mode = M_TIMED;
      checks++;
      if (cpu_halt !== (c != 29)) begin
        errors++; $display("FAIL mode_halt cycle %0d: got %b expected %b", c, cpu_halt, (c != 29));
      end
    end
    tick();
    checks++;
    if (active_cycles !== 32'd6) begin errors++; $display("FAIL mode_active: got %0d expected 6", active_cycles); end
  endtask

  task automatic test_step();
    int lows;
    do_reset(M_STEP);
    for (int k = 0; k < 8; k++) begin
      step_btn = ((k / 2) % 2 == 0);
      checks++;
      if (cpu_halt !== 1'b1) begin errors++; $display("FAIL step_bounce_halt k=%0d: got %b expected 1", k, cpu_halt); end
      tick();
    end
    step_btn = 1'b1;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (cpu_halt !== (k != 11)) begin
        errors++; $display("FAIL step_hold_halt k=%0d: got %b expected %b", k, cpu_halt, (k != 11));
      end
      if (cpu_halt === 1'b0) lows++;
      tick();
    end
    checks += 2;
    if (lows != 1) begin errors++; $display("FAIL step_single_pulse: got %0d pulses expected 1", lows); end
    if (active_cycles !== 32'd1) begin errors++; $display("FAIL step_active: got %0d expected 1", active_cycles); end
    step_btn = 1'b0;
    for (int k = 0; k < 33; k++) begin
      step_btn = (k >= 15 && k < 18);
      checks++;
      if (cpu_halt !== 1'b1) begin errors++; $display("FAIL step_release_halt k=%0d: got %b expected 1", k, cpu_halt); end
      tick();
    end
    checks++;
    if (active_cycles !== 32'd1) begin errors++; $display("FAIL step_release_active: got %0d expected 1", active_cycles); end
  endtask

  task automatic test_led();
    logic [31:0] addrs [6];
    logic [31:0] datas [6];
    logic        wrn   [6];
    logic [3:0]  exp_oh [6];
    logic [3:0]  exp_raw [6];
    addrs = '{32'h1, 32'h2, 32'h1, 32'h1, 32'h8000_0001, 32'h1};
    datas = '{32'h2, 32'h1, 32'h3, 32'hA, 32'h0, 32'h3};
    wrn   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_oh  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    exp_raw = '{4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b0011};
    do_reset(M_HOLD);
    for (int v = 0; v < 6; v++) begin
      dmem_addr = addrs[v]; dmem_wdata = datas[v]; dmem_read_wrn = wrn[v];
      tick();
      dmem_read_wrn = 1'b1; dmem_addr = 32'h0;
      checks += 2;
      if (leds !== exp_oh[v]) begin errors++; $display("FAIL led_onehot vec %0d: got %b expected %b", v, leds, exp_oh[v]); end
      if (r_leds !== exp_raw[v]) begin errors++; $display("FAIL led_raw vec %0d: got %b expected %b", v, r_leds, exp_raw[v]); end
      repeat (2) tick();
      checks++;
      if (leds !== exp_oh[v]) begin errors++; $display("FAIL led_hold vec %0d: got %b expected %b", v, leds, exp_oh[v]); end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset(M_RUN);
    repeat (10) tick();
    dmem_read_wrn = 1'b0; dmem_addr = 32'h1; dmem_wdata = 32'h0;
    tick();
    dmem_read_wrn = 1'b1;
    repeat (26) tick();
    checks += 2;
    if (leds !== 4'b0001) begin errors++; $display("FAIL midrun_leds_pre: got %b expected 0001", leds); end
    if (active_cycles !== 32'd37) begin errors++; $display("FAIL midrun_active_pre: got %0d expected 37", active_cycles); end
    sw0 = 1'b1; dmem_read_wrn = 1'b0; dmem_addr = 32'h1; dmem_wdata = 32'h3;
    tick();
    checks += 5;
    if (leds !== 4'b0000) begin errors++; $display("FAIL midrun_leds: got %b expected 0000", leds); end
    if (r_leds !== 4'b0000) begin errors++; $display("FAIL midrun_raw_leds: got %b expected 0000", r_leds); end
    if (active_cycles !== 32'd0) begin errors++; $display("FAIL midrun_active: got %0d expected 0", active_cycles); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL midrun_rst_n: got %b expected 0", cpu_rst_n); end
    if (cpu_halt !== 1'b1) begin errors++; $display("FAIL midrun_halt: got %b expected 1", cpu_halt); end
    dmem_read_wrn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_timed();
    test_mode_change();
    test_step();
    test_led();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
